// File: rtl/xge_pkt_rx_reader.sv
// xge_pkt_rx_reader: host-side reader for the XGE MAC pkt_rx_* interface.
// Issues read enables while buffer room allows, checks SOP/EOP framing,
// measures frame length and drains words through a first-word
// fall-through FIFO as a valid/ready stream.
// Optional build macro XGE_RX_STATS_EN adds frame/error/byte counters
// with a synchronous clear (stats_clr).
//
// Handshake: a word moves downstream on every cycle where
// out_valid && out_ready. out_* hold steady while out_valid && !out_ready.
// On the MAC side, a word is presented with pkt_rx_val exactly one cycle
// after pkt_rx_ren.
module xge_pkt_rx_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk_156m25,
    input  logic             reset_156m25_n,
    input  logic             pkt_rx_avail,
    output logic             pkt_rx_ren,
    input  logic [63:0]      pkt_rx_data,
    input  logic             pkt_rx_val,
    input  logic             pkt_rx_sop,
    input  logic             pkt_rx_eop,
    input  logic [2:0]       pkt_rx_mod,
    input  logic             pkt_rx_err,
    output logic [63:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sop,
    output logic             out_eop,
    output logic [2:0]       out_mod,
    output logic             out_err,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_len_vld,
`ifdef XGE_RX_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] rx_frame_cnt,
    output logic [CNT_W-1:0] rx_err_cnt,
    output logic [CNT_W-1:0] rx_frame_err_cnt,
    output logic [CNT_W-1:0] rx_byte_cnt,
`endif
    output logic             dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] ONE_C   = 1;
    localparam logic [AW:0] TWO_C   = 2;

    typedef enum logic {IDLE, READ} state_t;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } entry_t;

    state_t          state_q, state_d;
    entry_t          mem_q [FIFO_DEPTH];
    entry_t          wr_entry, head;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d, free_slots;
    logic            push, pop;
    logic            in_frame_q, in_frame_d;
    logic [LEN_W-1:0] len_q, len_d, len_sat;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;
    logic            frame_len_vld_q, frame_len_vld_d;
    logic [LEN_W:0]  len_sum;
    logic [3:0]      word_bytes;

    assign free_slots = DEPTH_C - count_q;
    assign pop        = (count_q != '0) && out_ready;
    assign word_bytes = (pkt_rx_eop && (pkt_rx_mod != 3'd0)) ? {1'b0, pkt_rx_mod} : 4'd8;
    assign dbg_state  = (state_q == READ);

    // Read FSM: ren is combinational so it drops in the same cycle as EOP capture.
    always_comb begin
        state_d    = state_q;
        pkt_rx_ren = 1'b0;
        case (state_q)
            IDLE: if (pkt_rx_avail && (free_slots >= TWO_C)) state_d = READ;
            READ: begin
                if (pkt_rx_val && pkt_rx_eop) state_d = IDLE;
                else                          pkt_rx_ren = (free_slots >= TWO_C);
            end
            default: state_d = IDLE;
        endcase
    end

    // Framing check and length accumulation for each captured word.
    always_comb begin
        push            = 1'b0;
        wr_entry.data   = pkt_rx_data;
        wr_entry.sop    = pkt_rx_sop;
        wr_entry.eop    = pkt_rx_eop;
        wr_entry.mod    = pkt_rx_mod;
        wr_entry.err    = pkt_rx_err;
        in_frame_d      = in_frame_q;
        len_d           = len_q;
        frame_len_d     = frame_len_q;
        frame_len_vld_d = 1'b0;
        len_sum         = '0;
        if (pkt_rx_val) begin
            if (pkt_rx_sop) begin
                // A SOP inside an open frame restarts the frame and is flagged.
                push         = 1'b1;
                wr_entry.err = pkt_rx_err | in_frame_q;
                len_sum      = (LEN_W+1)'(word_bytes);
            end else if (in_frame_q) begin
                push    = 1'b1;
                len_sum = {1'b0, len_q} + (LEN_W+1)'(word_bytes);
            end
        end
        len_sat = len_sum[LEN_W] ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];
        if (push) begin
            in_frame_d = !pkt_rx_eop;
            len_d      = len_sat;
            if (pkt_rx_eop) begin
                frame_len_d     = len_sat;
                frame_len_vld_d = 1'b1;
            end
        end
    end

    // FIFO occupancy update; push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    // Control state, pointers and length registers.
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            in_frame_q      <= 1'b0;
            len_q           <= '0;
            frame_len_q     <= '0;
            frame_len_vld_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            in_frame_q      <= in_frame_d;
            len_q           <= len_d;
            frame_len_q     <= frame_len_d;
            frame_len_vld_q <= frame_len_vld_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk_156m25) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head          = mem_q[rd_ptr_q];
    assign out_valid     = (count_q != '0);
    assign out_data      = out_valid ? head.data : 64'd0;
    assign out_sop       = out_valid & head.sop;
    assign out_eop       = out_valid & head.eop;
    assign out_mod       = out_valid ? head.mod : 3'd0;
    assign out_err       = out_valid & head.err;
    assign frame_len     = frame_len_q;
    assign frame_len_vld = frame_len_vld_q;

    // The ren throttle must make a write into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk_156m25) disable iff (!reset_156m25_n)
        !(push && (count_q == DEPTH_C) && !pop));

`ifdef XGE_RX_STATS_EN
    logic             frame_err_ev, eop_ev, mac_err_q, mac_err_d;
    logic [CNT_W-1:0] frame_cnt_q, err_cnt_q, frame_err_cnt_q, byte_cnt_q;

    assign frame_err_ev = pkt_rx_val && (pkt_rx_sop ? in_frame_q : !in_frame_q);
    assign eop_ev       = push && pkt_rx_eop;
    assign mac_err_d    = pkt_rx_sop ? pkt_rx_err : (mac_err_q | pkt_rx_err);

    // Statistics; a clear in the same cycle as an event keeps that event.
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            mac_err_q       <= 1'b0;
            frame_cnt_q     <= '0;
            err_cnt_q       <= '0;
            frame_err_cnt_q <= '0;
            byte_cnt_q      <= '0;
        end else begin
            if (push) mac_err_q <= mac_err_d;
            frame_cnt_q     <= (stats_clr ? '0 : frame_cnt_q) + CNT_W'(eop_ev);
            err_cnt_q       <= (stats_clr ? '0 : err_cnt_q) + CNT_W'(eop_ev && mac_err_d);
            frame_err_cnt_q <= (stats_clr ? '0 : frame_err_cnt_q) + CNT_W'(frame_err_ev);
            byte_cnt_q      <= (stats_clr ? '0 : byte_cnt_q) + (eop_ev ? CNT_W'(len_sat) : '0);
        end
    end

    assign rx_frame_cnt     = frame_cnt_q;
    assign rx_err_cnt       = err_cnt_q;
    assign rx_frame_err_cnt = frame_err_cnt_q;
    assign rx_byte_cnt      = byte_cnt_q;
`endif

endmodule

// File: tb/tb_xge_pkt_rx_reader.sv
// Testbench for xge_pkt_rx_reader: MAC-side driver, directed frames,
// expected-queue scoreboard for the output stream and frame lengths.
module tb_xge_pkt_rx_reader;

    localparam int W = 70;

    logic        clk;
    logic        rst_n;
    logic        pkt_rx_avail, pkt_rx_ren, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err;
    logic [63:0] pkt_rx_data;
    logic [2:0]  pkt_rx_mod;
    logic [63:0] out_data;
    logic        out_valid, out_ready, out_sop, out_eop, out_err;
    logic [2:0]  out_mod;
    logic [15:0] frame_len;
    logic        frame_len_vld;
    logic        dbg_state;
`ifdef XGE_RX_STATS_EN
    logic        stats_clr;
    logic [31:0] rx_frame_cnt, rx_err_cnt, rx_frame_err_cnt, rx_byte_cnt;
`endif

    logic [W-1:0]  mac_q[$];
    logic [W-1:0]  exp_q[$];
    logic [15:0]   len_q[$];
    logic [W-1:0]  got_w, mon_w;
    logic [15:0]   mon_len;
    int            checks, errors, ren_cnt;

    xge_pkt_rx_reader #(.FIFO_DEPTH(4), .LEN_W(16), .CNT_W(32)) dut (
        .clk_156m25(clk), .reset_156m25_n(rst_n),
        .pkt_rx_avail(pkt_rx_avail), .pkt_rx_ren(pkt_rx_ren),
        .pkt_rx_data(pkt_rx_data), .pkt_rx_val(pkt_rx_val),
        .pkt_rx_sop(pkt_rx_sop), .pkt_rx_eop(pkt_rx_eop),
        .pkt_rx_mod(pkt_rx_mod), .pkt_rx_err(pkt_rx_err),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .out_mod(out_mod), .out_err(out_err),
        .frame_len(frame_len), .frame_len_vld(frame_len_vld),
`ifdef XGE_RX_STATS_EN
        .stats_clr(stats_clr), .rx_frame_cnt(rx_frame_cnt), .rx_err_cnt(rx_err_cnt),
        .rx_frame_err_cnt(rx_frame_err_cnt), .rx_byte_cnt(rx_byte_cnt),
`endif
        .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #3 clk = ~clk;

    assign got_w = {out_data, out_sop, out_eop, out_mod, out_err};

    // MAC model: a ren seen in one cycle returns the next queued word in the following cycle.
    initial begin
        logic         ren_seen;
        logic [W-1:0] w;
        forever begin
            @(negedge clk);
            ren_seen = pkt_rx_ren;
            @(posedge clk);
            #1;
            if (ren_seen && mac_q.size() != 0) begin
                w = mac_q.pop_front();
                {pkt_rx_data, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, pkt_rx_err} = w;
                pkt_rx_val = 1'b1;
            end else begin
                pkt_rx_val  = 1'b0;
                pkt_rx_sop  = 1'b0;
                pkt_rx_eop  = 1'b0;
                pkt_rx_err  = 1'b0;
                pkt_rx_mod  = 3'd0;
                pkt_rx_data = 64'd0;
            end
            pkt_rx_avail = (mac_q.size() != 0);
        end
    end

    // Monitor: compare every accepted output word and every length pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pkt_rx_ren) ren_cnt++;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_word: got %h, none expected", got_w);
                end else begin
                    mon_w = exp_q.pop_front();
                    if (got_w !== mon_w) begin
                        errors++;
                        $display("FAIL out_word: got %h expected %h", got_w, mon_w);
                    end
                end
            end
            if (frame_len_vld) begin
                checks++;
                if (len_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_len: got %0d, no pulse expected", frame_len);
                end else begin
                    mon_len = len_q.pop_front();
                    if (frame_len !== mon_len) begin
                        errors++;
                        $display("FAIL frame_len: got %0d expected %0d", frame_len, mon_len);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic mac_word(input logic [63:0] d, input logic s, input logic e,
                            input logic [2:0] m, input logic er);
        mac_q.push_back({d, s, e, m, er});
    endtask

    task automatic exp_word(input logic [63:0] d, input logic s, input logic e,
                            input logic [2:0] m, input logic er);
        exp_q.push_back({d, s, e, m, er});
    endtask

    // Error-free frame of n words, data base+i; also expected verbatim at the output.
    task automatic clean_frame(input int n, input logic [63:0] base, input logic [2:0] m);
        for (int i = 0; i < n; i++) begin
            mac_word(base + 64'(i), i == 0, i == n - 1, (i == n - 1) ? m : 3'd0, 1'b0);
            exp_word(base + 64'(i), i == 0, i == n - 1, (i == n - 1) ? m : 3'd0, 1'b0);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((mac_q.size() != 0 || exp_q.size() != 0 || len_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s: timeout, words left %0d expected 0", name, exp_q.size());
        end
        tick();
        tick();
    endtask

    initial begin
        checks = 0; errors = 0; ren_cnt = 0;
        rst_n = 1'b0; out_ready = 1'b1;
        pkt_rx_avail = 1'b0; pkt_rx_val = 1'b0; pkt_rx_sop = 1'b0; pkt_rx_eop = 1'b0;
        pkt_rx_err = 1'b0; pkt_rx_mod = 3'd0; pkt_rx_data = 64'd0;
`ifdef XGE_RX_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) tick();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_ren", 64'(pkt_rx_ren), 64'd0);
        check("reset_frame_len", 64'(frame_len), 64'd0);
        check("reset_len_vld", 64'(frame_len_vld), 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;
        tick();

        // 64-byte frame, eight full words
        ren_cnt = 0;
        clean_frame(8, 64'hA000_0000_0000_0000, 3'd0);
        len_q.push_back(16'd64);
        wait_drain("t1_drain");
        check("t1_ren_cycles", 64'(ren_cnt), 64'd8);

        // single-word frame, mod=5
        ren_cnt = 0;
        mac_word(64'hB0B1_B2B3_B4B5_B6B7, 1'b1, 1'b1, 3'd5, 1'b0);
        exp_word(64'hB0B1_B2B3_B4B5_B6B7, 1'b1, 1'b1, 3'd5, 1'b0);
        len_q.push_back(16'd5);
        wait_drain("t2_drain");
        check("t2_ren_cycles", 64'(ren_cnt), 64'd1);

        // 20-word frame against a stalled sink
        ren_cnt = 0;
        out_ready = 1'b0;
        clean_frame(20, 64'hC000_0000_0000_0100, 3'd0);
        len_q.push_back(16'd160);
        repeat (30) tick();
        check("t3_mac_left", 64'(mac_q.size()), 64'd16);
        check("t3_ren_held", 64'(pkt_rx_ren), 64'd0);
        check("t3_valid", 64'(out_valid), 64'd1);
        check("t3_head_data", out_data, 64'hC000_0000_0000_0100);
        out_ready = 1'b1;
        wait_drain("t3_drain");
        check("t3_ren_cycles", 64'(ren_cnt), 64'd20);

        // stray word outside a frame is dropped
        mac_word(64'hDDDD_0000_0000_0001, 1'b0, 1'b1, 3'd3, 1'b0);
        wait_drain("t4a_drain");
`ifdef XGE_RX_STATS_EN
        check("t4_frame_err_1", rx_frame_err_cnt, 64'd1);
`endif
        // SOP inside an open frame restarts it and is flagged
        mac_word(64'hE000_0000_0000_0000, 1'b1, 1'b0, 3'd0, 1'b0);
        exp_word(64'hE000_0000_0000_0000, 1'b1, 1'b0, 3'd0, 1'b0);
        mac_word(64'hE000_0000_0000_0001, 1'b1, 1'b0, 3'd0, 1'b0);
        exp_word(64'hE000_0000_0000_0001, 1'b1, 1'b0, 3'd0, 1'b1);
        mac_word(64'hE000_0000_0000_0002, 1'b0, 1'b1, 3'd4, 1'b0);
        exp_word(64'hE000_0000_0000_0002, 1'b0, 1'b1, 3'd4, 1'b0);
        len_q.push_back(16'd12);
        wait_drain("t4b_drain");
`ifdef XGE_RX_STATS_EN
        check("t4_frame_err_2", rx_frame_err_cnt, 64'd2);
`endif

        // MAC error on the EOP word of a 3-word frame
        mac_word(64'hF000_0000_0000_0000, 1'b1, 1'b0, 3'd0, 1'b0);
        exp_word(64'hF000_0000_0000_0000, 1'b1, 1'b0, 3'd0, 1'b0);
        mac_word(64'hF000_0000_0000_0001, 1'b0, 1'b0, 3'd0, 1'b0);
        exp_word(64'hF000_0000_0000_0001, 1'b0, 1'b0, 3'd0, 1'b0);
        mac_word(64'hF000_0000_0000_0002, 1'b0, 1'b1, 3'd3, 1'b1);
        exp_word(64'hF000_0000_0000_0002, 1'b0, 1'b1, 3'd3, 1'b1);
        len_q.push_back(16'd19);
        wait_drain("t5_drain");
`ifdef XGE_RX_STATS_EN
        check("t5_frame_cnt", rx_frame_cnt, 64'd5);
        check("t5_err_cnt", rx_err_cnt, 64'd1);
        check("t5_frame_err_cnt", rx_frame_err_cnt, 64'd2);
        check("t5_byte_cnt", rx_byte_cnt, 64'd260);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("clr_frame_cnt", rx_frame_cnt, 64'd0);
        check("clr_err_cnt", rx_err_cnt, 64'd0);
        check("clr_frame_err_cnt", rx_frame_err_cnt, 64'd0);
        check("clr_byte_cnt", rx_byte_cnt, 64'd0);
`endif

        // reset in the middle of a partially buffered frame
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            mac_word(64'h6000_0000_0000_0000 + 64'(i), i == 0, i == 5, 3'd0, 1'b0);
        repeat (8) tick();
        check("t6_valid_before", 64'(out_valid), 64'd1);
        check("t6_frame_len_before", 64'(frame_len), 64'd19);
        rst_n = 1'b0;
        mac_q.delete();
        #1;
        check("t6_valid_in_reset", 64'(out_valid), 64'd0);
        check("t6_frame_len_in_reset", 64'(frame_len), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        clean_frame(2, 64'h7000_0000_0000_0000, 3'd2);
        len_q.push_back(16'd10);
        wait_drain("t6_drain");
        check("t6_state_idle", 64'(dbg_state), 64'd0);

        check("final_exp_left", 64'(exp_q.size()), 64'd0);
        check("final_len_left", 64'(len_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
